// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, divider FSM states and divide context.
package alu_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic [4:0] {
        ALU_SUB    = 5'd0,
        ALU_ADD    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRA    = 5'd6,
        ALU_SRL    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_ADDR   = 5'd10,
        ALU_BEQ    = 5'd11,
        ALU_BNE    = 5'd12,
        ALU_BLT    = 5'd13,
        ALU_BGE    = 5'd14,
        ALU_BLTU   = 5'd15,
        ALU_BGEU   = 5'd16,
        ALU_JAL    = 5'd17,
        ALU_JALR   = 5'd18,
        ALU_LUI    = 5'd19,
        ALU_AUIPC  = 5'd20,
        ALU_MUL    = 5'd21,
        ALU_MULH   = 5'd22,
        ALU_MULHSU = 5'd23,
        ALU_MULHU  = 5'd24,
        ALU_DIV    = 5'd25,
        ALU_DIVU   = 5'd26,
        ALU_REM    = 5'd27,
        ALU_REMU   = 5'd28
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Sign fix-up applied when the iterative divide finishes.
    typedef struct packed {
        logic is_rem;
        logic neg_quot;
        logic neg_rem;
    } div_ctx_t;

    function automatic logic is_div_op(input logic [4:0] code);
        return (code >= 5'(ALU_DIV)) && (code <= 5'(ALU_REMU));
    endfunction

endpackage

// File: rtl/alu_div_iter.sv
// Restoring unsigned radix-2 divider; first bit is resolved on the start edge,
// so XLEN quotient bits take XLEN cycles from start.
module alu_div_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rem,
    output logic            done_c
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    logic [XLEN-1:0] divisor_q;
    logic [CW-1:0]   cnt;
    logic            busy;

    logic [XLEN-1:0] src_rem;
    logic [XLEN-1:0] src_quot;
    logic [XLEN-1:0] src_div;
    logic [XLEN:0]   trial;
    logic [XLEN:0]   diff;
    logic            ge;
    logic [XLEN-1:0] rem_n;
    logic [XLEN-1:0] quot_n;

    // One restoring step: shift in next dividend bit, subtract if it fits.
    always_comb begin
        src_rem  = start ? '0 : rem;
        src_quot = start ? dividend : quot;
        src_div  = start ? divisor : divisor_q;
        trial    = {src_rem, src_quot[XLEN-1]};
        diff     = trial - {1'b0, src_div};
        ge       = ~diff[XLEN];
        rem_n    = ge ? diff[XLEN-1:0] : {src_rem[XLEN-2:0], src_quot[XLEN-1]};
        quot_n   = {src_quot[XLEN-2:0], ge};
    end

    // High during the cycle whose edge computes the final quotient bit.
    assign done_c = busy && (cnt == LAST);

    // Iteration registers and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quot      <= '0;
            rem       <= '0;
            divisor_q <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
        end else if (abort) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            quot      <= quot_n;
            rem       <= rem_n;
            divisor_q <= divisor;
            cnt       <= CW'(1);
            busy      <= 1'b1;
        end else if (busy) begin
            quot <= quot_n;
            rem  <= rem_n;
            cnt  <= cnt + CW'(1);
            if (cnt == LAST) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU with registered result, branch flag and iterative divide.
module alu_exec
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [4:0]      aluctrl_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic            br_taken_o
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned PW  = 2 * XLEN;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e state, state_d;
    div_ctx_t   ctx, ctx_d;
    logic            valid_d;
    logic            br_d;
    logic [XLEN-1:0] result_d;
    logic            div_start;
    logic            div_abort;
    logic [XLEN-1:0] div_quot;
    logic [XLEN-1:0] div_rem;
    logic            div_done_c;

    logic [SHW-1:0]   shamt;
    logic [XLEN-1:0]  sum;
    logic [XLEN-1:0]  diff;
    logic             lt_s;
    logic             lt_u;
    logic             mul_a_sgn;
    logic             mul_b_sgn;
    logic signed [XLEN:0] mul_a;
    logic signed [XLEN:0] mul_b;
    logic signed [PW-1:0] prod;
    logic [XLEN-1:0]  alu_res_c;
    logic             alu_br_c;

    logic             accept;
    logic             div_signed;
    logic             a_neg;
    logic             b_neg;
    logic [XLEN-1:0]  a_mag;
    logic [XLEN-1:0]  b_mag;
    logic             div_zero;
    logic             div_ovf;
    logic             op_rem;

    // Shared adder, comparators and sign-selectable multiplier.
    always_comb begin
        shamt     = b_i[SHW-1:0];
        sum       = a_i + b_i;
        diff      = a_i - b_i;
        lt_s      = $signed(a_i) < $signed(b_i);
        lt_u      = a_i < b_i;
        mul_a_sgn = (aluctrl_i == ALU_MULH) || (aluctrl_i == ALU_MULHSU);
        mul_b_sgn = (aluctrl_i == ALU_MULH);
        mul_a     = {mul_a_sgn & a_i[XLEN-1], a_i};
        mul_b     = {mul_b_sgn & b_i[XLEN-1], b_i};
        prod      = PW'(mul_a) * PW'(mul_b);
    end

    // Single-cycle operation select.
    always_comb begin
        alu_res_c = '0;
        alu_br_c  = 1'b0;
        case (aluctrl_i)
            ALU_SUB:    alu_res_c = diff;
            ALU_ADD:    alu_res_c = sum;
            ALU_SLL:    alu_res_c = a_i << shamt;
            ALU_SLT:    alu_res_c = XLEN'(lt_s);
            ALU_SLTU:   alu_res_c = XLEN'(lt_u);
            ALU_XOR:    alu_res_c = a_i ^ b_i;
            ALU_SRA:    alu_res_c = XLEN'($signed(a_i) >>> shamt);
            ALU_SRL:    alu_res_c = a_i >> shamt;
            ALU_OR:     alu_res_c = a_i | b_i;
            ALU_AND:    alu_res_c = a_i & b_i;
            ALU_ADDR:   alu_res_c = sum;
            ALU_BEQ:    alu_br_c  = (a_i == b_i);
            ALU_BNE:    alu_br_c  = (a_i != b_i);
            ALU_BLT:    alu_br_c  = lt_s;
            ALU_BGE:    alu_br_c  = ~lt_s;
            ALU_BLTU:   alu_br_c  = lt_u;
            ALU_BGEU:   alu_br_c  = ~lt_u;
            ALU_JAL:    alu_res_c = sum;
            ALU_JALR:   alu_res_c = {sum[XLEN-1:1], 1'b0};
            ALU_LUI:    alu_res_c = b_i;
            ALU_AUIPC:  alu_res_c = sum;
            ALU_MUL:    alu_res_c = prod[XLEN-1:0];
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU:  alu_res_c = prod[PW-1:XLEN];
            default:    alu_res_c = '0;
        endcase
    end

    // Divide operand conditioning and special-case detection.
    always_comb begin
        div_signed = (aluctrl_i == ALU_DIV) || (aluctrl_i == ALU_REM);
        op_rem     = (aluctrl_i == ALU_REM) || (aluctrl_i == ALU_REMU);
        a_neg      = div_signed & a_i[XLEN-1];
        b_neg      = div_signed & b_i[XLEN-1];
        a_mag      = a_neg ? -a_i : a_i;
        b_mag      = b_neg ? -b_i : b_i;
        div_zero   = (b_i == '0);
        div_ovf    = div_signed && (a_i == INT_MIN) && (b_i == '1);
    end

    assign accept = start_i && ready_o;

    // Next-state and next-output logic; flush overrides everything.
    always_comb begin
        state_d   = state;
        ctx_d     = ctx;
        valid_d   = 1'b0;
        br_d      = 1'b0;
        result_d  = result_o;
        div_start = 1'b0;
        div_abort = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!is_div_op(aluctrl_i)) begin
                        result_d = alu_res_c;
                        br_d     = alu_br_c;
                        valid_d  = 1'b1;
                    end else if (div_zero) begin
                        result_d = op_rem ? a_i : '1;
                        valid_d  = 1'b1;
                    end else if (div_ovf) begin
                        result_d = op_rem ? '0 : a_i;
                        valid_d  = 1'b1;
                    end else begin
                        div_start      = 1'b1;
                        ctx_d.is_rem   = op_rem;
                        ctx_d.neg_quot = a_neg ^ b_neg;
                        ctx_d.neg_rem  = a_neg;
                        state_d        = DIV;
                    end
                end
            end
            DIV: begin
                if (div_done_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ctx.is_rem) begin
                    result_d = ctx.neg_rem ? -div_rem : div_rem;
                end else begin
                    result_d = ctx.neg_quot ? -div_quot : div_quot;
                end
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d   = IDLE;
            ctx_d     = ctx;
            valid_d   = 1'b0;
            br_d      = 1'b0;
            result_d  = result_o;
            div_start = 1'b0;
            div_abort = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            ctx        <= '0;
            ready_o    <= 1'b1;
            valid_o    <= 1'b0;
            result_o   <= '0;
            br_taken_o <= 1'b0;
        end else begin
            state      <= state_d;
            ctx        <= ctx_d;
            ready_o    <= (state_d == IDLE);
            valid_o    <= valid_d;
            result_o   <= result_d;
            br_taken_o <= br_d;
        end
    end

    alu_div_iter #(
        .XLEN (XLEN)
    ) u_div (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .start    (div_start),
        .abort    (div_abort),
        .dividend (a_mag),
        .divisor  (b_mag),
        .quot     (div_quot),
        .rem      (div_rem),
        .done_c   (div_done_c)
    );

endmodule

// File: tb/tb_alu_exec.sv
// Directed vector bench for alu_exec (XLEN = 32).
module tb_alu_exec;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        ready;
    logic        valid;
    logic [31:0] result;
    logic        br_taken;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        br;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    alu_exec dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .aluctrl_i  (code),
        .a_i        (a),
        .b_i        (b),
        .flush_i    (flush),
        .ready_o    (ready),
        .valid_o    (valid),
        .result_o   (result),
        .br_taken_o (br_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic addv(input logic [4:0] c, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] r, input logic br, input int lat);
        vec_t v;
        v.code = c; v.a = x; v.b = y; v.res = r; v.br = br; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Issue one op, wait (bounded) for valid; lat counts sampled cycles after accept.
    task automatic run_op(input logic [4:0] c, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] res, output logic br, output int lat, output int rlow);
        @(negedge clk);
        code = c; a = x; b = y; start = 1'b1;
        lat = 0; rlow = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (!ready) rlow++;
        end while (!valid && lat < 100);
        res = result;
        br  = br_taken;
    endtask

    initial begin
        logic [31:0] res;
        logic        br;
        int          lat;
        int          rlow;
        int          vcount;

        rst_n = 1'b0; start = 1'b0; code = '0; a = '0; b = '0; flush = 1'b0;
        #12;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_br", 32'(br_taken), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        addv(5'd1,  32'd5,        32'd7,        32'd12,       1'b0, 1);
        addv(5'd0,  32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1);
        addv(5'd2,  32'd1,        32'd35,       32'd8,        1'b0, 1);
        addv(5'd3,  32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1);
        addv(5'd4,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1);
        addv(5'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1);
        addv(5'd6,  32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1);
        addv(5'd7,  32'h80000000, 32'd4,        32'h08000000, 1'b0, 1);
        addv(5'd8,  32'h0F,       32'hF0,       32'hFF,       1'b0, 1);
        addv(5'd9,  32'hFF,       32'h3C,       32'h3C,       1'b0, 1);
        addv(5'd10, 32'hFFFFFFFF, 32'd2,        32'd1,        1'b0, 1);
        addv(5'd11, 32'd5,        32'd5,        32'd0,        1'b1, 1);
        addv(5'd12, 32'd5,        32'd5,        32'd0,        1'b0, 1);
        addv(5'd13, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1);
        addv(5'd14, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1);
        addv(5'd15, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1);
        addv(5'd16, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1);
        addv(5'd17, 32'h100,      32'd4,        32'h104,      1'b0, 1);
        addv(5'd18, 32'h101,      32'd4,        32'h104,      1'b0, 1);
        addv(5'd19, 32'd123,      32'hABCDE000, 32'hABCDE000, 1'b0, 1);
        addv(5'd20, 32'h1000,     32'h2000,     32'h3000,     1'b0, 1);
        addv(5'd21, 32'hFFFFFFFF, 32'd3,        32'hFFFFFFFD, 1'b0, 1);
        addv(5'd22, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1);
        addv(5'd23, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0, 1);
        addv(5'd24, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1);
        addv(5'd29, 32'd5,        32'd7,        32'd0,        1'b0, 1);
        addv(5'd31, 32'd5,        32'd5,        32'd0,        1'b0, 1);
        addv(5'd25, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 33);
        addv(5'd27, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 33);
        addv(5'd26, 32'd100,      32'd7,        32'd14,       1'b0, 33);
        addv(5'd28, 32'd100,      32'd7,        32'd2,        1'b0, 33);
        addv(5'd25, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33);
        addv(5'd27, 32'd7,        32'hFFFFFFFE, 32'd1,        1'b0, 33);
        addv(5'd25, 32'h80000000, 32'd2,        32'hC0000000, 1'b0, 33);
        addv(5'd26, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 1'b0, 33);
        addv(5'd26, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0, 33);
        addv(5'd28, 32'd3,        32'd10,       32'd3,        1'b0, 33);
        addv(5'd26, 32'd9,        32'd0,        32'hFFFFFFFF, 1'b0, 1);
        addv(5'd28, 32'd9,        32'd0,        32'd9,        1'b0, 1);
        addv(5'd25, 32'd9,        32'd0,        32'hFFFFFFFF, 1'b0, 1);
        addv(5'd27, 32'd9,        32'd0,        32'd9,        1'b0, 1);
        addv(5'd25, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1);
        addv(5'd27, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0, 1);

        foreach (vecs[i]) begin
            run_op(vecs[i].code, vecs[i].a, vecs[i].b, res, br, lat, rlow);
            check($sformatf("v%0d_code%0d_result", i, vecs[i].code), res, vecs[i].res);
            check($sformatf("v%0d_code%0d_br", i, vecs[i].code), 32'(br), 32'(vecs[i].br));
            check($sformatf("v%0d_code%0d_latency", i, vecs[i].code), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_code%0d_ready_low", i, vecs[i].code), 32'(rlow), 32'(vecs[i].lat - 1));
        end

        // Back-to-back single-cycle ops, then result holds with no valid.
        @(negedge clk);
        code = 5'd1; a = 32'd5; b = 32'd7; start = 1'b1;
        @(negedge clk);
        check("b2b_first_valid", 32'(valid), 32'd1);
        check("b2b_first_result", result, 32'd12);
        code = 5'd0; a = 32'd3; b = 32'd5;
        @(negedge clk);
        check("b2b_second_valid", 32'(valid), 32'd1);
        check("b2b_second_result", result, 32'hFFFFFFFE);
        start = 1'b0;
        @(negedge clk);
        check("b2b_idle_valid", 32'(valid), 32'd0);
        check("b2b_hold_result", result, 32'hFFFFFFFE);

        // Branch flag drops with valid.
        run_op(5'd13, 32'hFFFFFFFF, 32'd1, res, br, lat, rlow);
        check("br_taken_on_valid", 32'(br), 32'd1);
        @(negedge clk);
        check("br_after_valid", 32'(br_taken), 32'd0);
        check("br_after_valid_v", 32'(valid), 32'd0);

        // start while busy is ignored.
        @(negedge clk);
        code = 5'd26; a = 32'd100; b = 32'd7; start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin code = 5'd1; a = 32'd1; b = 32'd1; start = 1'b1; end
            if (lat == 6) start = 1'b0;
        end while (!valid && lat < 100);
        check("busy_ignore_result", result, 32'd14);
        check("busy_ignore_latency", 32'(lat), 32'd33);
        vcount = 0;
        repeat (3) begin @(negedge clk); if (valid) vcount++; end
        check("busy_ignore_no_extra", 32'(vcount), 32'd0);

        // Flush at iteration 10.
        @(negedge clk);
        code = 5'd25; a = 32'hFFFFFFF9; b = 32'd2; start = 1'b1;
        vcount = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (valid) vcount++;
        end
        flush = 1'b1; start = 1'b1; code = 5'd1; a = 32'd1; b = 32'd1;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        check("flush_valid", 32'(valid), 32'd0);
        check("flush_ready", 32'(ready), 32'd1);
        check("flush_hold_result", result, 32'd14);
        repeat (40) begin @(negedge clk); if (valid) vcount++; end
        check("flush_no_valid", 32'(vcount), 32'd0);
        run_op(5'd1, 32'd2, 32'd3, res, br, lat, rlow);
        check("flush_next_add", res, 32'd5);
        check("flush_next_lat", 32'(lat), 32'd1);

        // Reset at iteration 10.
        @(negedge clk);
        code = 5'd27; a = 32'd100; b = 32'd7; start = 1'b1;
        vcount = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (valid) vcount++;
        end
        rst_n = 1'b0;
        #1;
        check("rst_mid_ready", 32'(ready), 32'd1);
        check("rst_mid_valid", 32'(valid), 32'd0);
        check("rst_mid_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin @(negedge clk); if (valid) vcount++; end
        check("rst_no_valid", 32'(vcount), 32'd0);
        run_op(5'd1, 32'd4, 32'd6, res, br, lat, rlow);
        check("rst_next_add", res, 32'd10);
        check("rst_next_lat", 32'(lat), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
